window_fetch: RTL and testbench
===============================

# window_fetch

Parametrised sliding-window fetcher for the VAD feature path. It buffers whole feature frames of `FRAME_LEN` samples in a two-deep ping-pong store. It emits one window of `WIN` consecutive samples per cycle, advancing by `STRIDE`, with optional zero padding at both frame edges. Valid/ready handshakes on both sides let the next frame load while the current one is being windowed. It feeds the binary convolution stage.

## Interface
Parameters:
- `W`, 16, sample width in bits.
- `FRAME_LEN`, 20, samples per input frame.
- `WIN`, 5, samples per output window.
- `STRIDE`, 3, sample offset between consecutive windows. Legal range is 1..WIN.
- `PAD`, 0, zero samples virtually added before and after the frame.

Derived:
- `NWIN` = floor((FRAME_LEN+2·PAD−WIN)/STRIDE)+1. The default is 6.
- Parameter check: elaboration error if FRAME_LEN+2·PAD < WIN.

Ports:
- `clk`, in, 1, clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `clear`, in, 1, synchronous flush of both buffers and the output register.
- `in_valid`, in, 1, frame present on `in_data`.
- `in_ready`, out, 1, at least one frame buffer is free.
- `in_data`, in, FRAME_LEN·W, sample i at bits [i·W +: W].
- `out_valid`, out, 1, window present on `out_data`.
- `out_ready`, in, 1, consumer accepts the window.
- `out_data`, out, WIN·W, window element k at bits [k·W +: W].
- `out_idx`, out, clog2(NWIN), index of the window within its frame.
- `out_last`, out, 1, marks window NWIN−1 of the frame.
- `empty`, out, 1, both buffers free and no window pending. This is the frame request to upstream.

## Operation
- Window n, element k = frame[n·STRIDE + k − PAD]. The element is 0 if the index falls outside 0..FRAME_LEN−1.
- Frame samples beyond the last window's reach are discarded.
- Input transfer occurs on `in_valid && in_ready`. The frame goes into the write-pointer buffer, which is marked full, and the write pointer toggles.
- Buffer state is held as a 2-bit full mask plus separate read and write pointers.
- `in_ready` = !(both full). It is registered and does not depend on `out_ready`.
- Output register loads when `(!out_valid || out_ready)` and the read buffer is full. It then holds window `win_cnt` of that buffer.
- Loading window NWIN−1 does three things: clears that buffer's full bit, toggles the read pointer, and resets `win_cnt` to 0.
- When no load occurs and `out_ready` is high, `out_valid` drops to 0.
- While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- `empty` = no buffer full and `!out_valid`.
- Simultaneous input accept and buffer release in one cycle: both take effect, and the full mask reflects both.
- `clear` behaviour:
  - It has priority over any handshake that cycle, with no transfer on either side.
  - It empties both buffers, zeroes both pointers and `win_cnt`, and drops `out_valid`.
  - A frame partially windowed at that point is lost.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0.
  - `in_ready`=1, `empty`=1.
  - Full mask=0, both pointers=0, `win_cnt`=0.
- Latency: a frame accepted at edge T produces window 0 with `out_valid`=1 after edge T+1.
- Throughput: one window per cycle with `out_ready` held high.
- A frame occupies its buffer for NWIN output loads.
- Back-to-back frames: if frame B is already loaded, window 0 of B follows window NWIN−1 of A on the next cycle with no bubble.
- With sustained `out_ready`=1, upstream sees `in_ready` deassert only if it delivers a frame faster than every NWIN cycles.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronous). Buffered data is dropped.

## Structure
- Package `window_fetch_pkg`:
  - `nwin(FRAME_LEN,WIN,STRIDE,PAD)` function.
  - Index-width function.
  - Typedef for the packed sample vector.
- Sub-module `window_fetch_buf`: two-entry frame store with full mask and pointers, exposing the read-buffer frame. The window mux and output register stay in the top module.

## Test plan
- Defaults, frame i→i+1 (1..20), `out_ready`=1 → six windows:
  - Windows 0..5 start at 1, 4, 7, 10, 13, 16. Window 0 = {1,2,3,4,5}, window 5 = {16..20}.
  - `out_last` high only on window 5.
  - First `out_valid` one cycle after accept.
- Two frames back-to-back (1..20, then 101..120) → 12 consecutive valid cycles with no gap.
- Third frame offered while both buffers are full → `in_ready`=0 until frame 1's last window loads.
- `out_ready` toggled 1,0,0,1 → `out_data` stable while stalled. No window is dropped or duplicated; sequence order is 0..5.
- PAD=2, STRIDE=2 (NWIN=10), frame 1..20:
  - Window 0 = {0,0,1,2,3}.
  - Window 9 = {17,18,19,20,0}.
- `clear` pulsed after window 2, and separately `rst_n` low mid-frame:
  - Outputs go to their reset values and `empty`=1.
  - The next frame restarts at window 0.

Source files
------------

// File: rtl/window_fetch_pkg.sv
// Shared helpers for the sliding-window fetcher: window count and index width
// derived from the frame geometry, plus the default sample type.
package window_fetch_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic int nwin(input int frame_len, input int win,
                                input int stride, input int pad);
        return (frame_len + 2 * pad - win) / stride + 1;
    endfunction

    // A single-window configuration still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_fetch_if.sv
// Frame-in / window-out handshake bundle of the window fetcher, plus the
// flush and idle status lines that travel with it.
interface window_fetch_if
    import window_fetch_pkg::*;
#(
    parameter int W         = 16,
    parameter int FRAME_LEN = 20,
    parameter int WIN       = 5,
    parameter int STRIDE    = 3,
    parameter int PAD       = 0
) ();

    localparam int NWIN  = nwin(FRAME_LEN, WIN, STRIDE, PAD);
    localparam int IDX_W = idx_width(NWIN);

    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [FRAME_LEN*W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIN*W-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   empty;

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, empty
    );

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, empty
    );

endinterface

// File: rtl/window_fetch_buf.sv
// Two-entry ping-pong frame store: full mask, independent read/write pointers
// and a registered ready that only depends on the mask.
module window_fetch_buf #(
    parameter int FRAME_W = 320
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_wr_en,
    input  logic [FRAME_W-1:0] i_wr_data,
    input  logic               i_rd_release,
    output logic               o_in_ready,
    output logic               o_rd_full,
    output logic               o_any_full,
    output logic [FRAME_W-1:0] o_rd_data
);

    logic [FRAME_W-1:0] r_mem [2];
    logic [1:0]         r_full;
    logic [1:0]         w_full_nxt;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_in_ready;

    // NOTE: every path starts from a default so no latch is inferred.
    always_comb begin
        w_full_nxt = r_full;
        if (i_rd_release) w_full_nxt[r_rd_ptr] = 1'b0;
        if (i_wr_en)      w_full_nxt[r_wr_ptr] = 1'b1;
        if (i_clear)      w_full_nxt           = '0;
    end

    // NOTE: state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_full     <= w_full_nxt;
            r_in_ready <= ~&w_full_nxt;
            if (i_clear) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (i_wr_en)      r_wr_ptr <= ~r_wr_ptr;
                if (i_rd_release) r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // NOTE: frame storage is not reset; the full mask alone says what is valid.
    always_ff @(posedge clk) begin
        if (i_wr_en && !i_clear) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_in_ready = r_in_ready;
    assign o_rd_full  = r_full[r_rd_ptr];
    assign o_any_full = |r_full;
    assign o_rd_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/window_fetch.sv
// Sliding-window fetcher: buffers whole frames and emits one zero-padded
// window of WIN samples per accepted output beat, advancing by STRIDE.
module window_fetch
    import window_fetch_pkg::*;
#(
    parameter int W         = 16,
    parameter int FRAME_LEN = 20,
    parameter int WIN       = 5,
    parameter int STRIDE    = 3,
    parameter int PAD       = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    window_fetch_if.slave if_bus
);

    localparam int               NWIN     = nwin(FRAME_LEN, WIN, STRIDE, PAD);
    localparam int               IDX_W    = idx_width(NWIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWIN - 1);

    if (FRAME_LEN + 2 * PAD < WIN) begin : g_bad_geometry
        $error("window_fetch: FRAME_LEN + 2*PAD must be at least WIN");
    end
    if (STRIDE < 1 || STRIDE > WIN) begin : g_bad_stride
        $error("window_fetch: STRIDE must lie in 1..WIN");
    end

    logic                   w_accept;
    logic                   w_load;
    logic                   w_release;
    logic                   w_in_ready;
    logic                   w_rd_full;
    logic                   w_any_full;
    logic [FRAME_LEN*W-1:0] w_rd_frame;
    logic [WIN*W-1:0]       w_window;

    logic [IDX_W-1:0]       r_win_cnt;
    logic                   r_out_valid;
    logic [WIN*W-1:0]       r_out_data;
    logic [IDX_W-1:0]       r_out_idx;
    logic                   r_out_last;

    // Clear wins over both handshakes in the same cycle.
    assign w_accept  = if_bus.in_valid && w_in_ready && !if_bus.clear;
    assign w_load    = (!r_out_valid || if_bus.out_ready) && w_rd_full && !if_bus.clear;
    assign w_release = w_load && (r_win_cnt == LAST_IDX);

    window_fetch_buf #(
        .FRAME_W (FRAME_LEN * W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (if_bus.clear),
        .i_wr_en      (w_accept),
        .i_wr_data    (if_bus.in_data),
        .i_rd_release (w_release),
        .o_in_ready   (w_in_ready),
        .o_rd_full    (w_rd_full),
        .o_any_full   (w_any_full),
        .o_rd_data    (w_rd_frame)
    );

    // Positions in the virtual padding read as zero.
    function automatic logic [W-1:0] sample_at(input logic [FRAME_LEN*W-1:0] frame,
                                               input int pos);
        if (pos < 0 || pos >= FRAME_LEN) return '0;
        return frame[pos*W +: W];
    endfunction

    always_comb begin
        w_window = '0;
        for (int k = 0; k < WIN; k++) begin
            w_window[k*W +: W] = sample_at(w_rd_frame, int'(r_win_cnt) * STRIDE + k - PAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (if_bus.clear) begin
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_window;
            r_out_idx   <= r_win_cnt;
            r_out_last  <= (r_win_cnt == LAST_IDX);
            r_win_cnt   <= (r_win_cnt == LAST_IDX) ? '0 : r_win_cnt + 1'b1;
        end else if (if_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign if_bus.in_ready  = w_in_ready;
    assign if_bus.out_valid = r_out_valid;
    assign if_bus.out_data  = r_out_data;
    assign if_bus.out_idx   = r_out_idx;
    assign if_bus.out_last  = r_out_last;
    assign if_bus.empty     = !w_any_full && !r_out_valid;

endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch: default geometry (stride 3, no pad) and a padded
// geometry (stride 2, pad 2) side by side, with a formula-based scoreboard.
module tb_window_fetch;
    import window_fetch_pkg::*;

    localparam int FL = 20;
    localparam int WN = 5;
    localparam int FW = FL * 16;
    localparam int OW = WN * 16;

    typedef struct {
        logic [7:0]    idx;
        logic          last;
        logic [OW-1:0] data;
    } vec_t;

    typedef struct {
        logic          in_valid, in_ready, clear, out_valid, out_ready, out_last, empty;
        logic [FW-1:0] in_data;
        logic [OW-1:0] out_data;
        logic [7:0]    out_idx;
    } snap_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   acc [2];
    int   pop [2];
    vec_t q_a [$];
    vec_t q_b [$];
    vec_t tab [6];
    vec_t pad_tab [2];

    window_fetch_if #(.W(16), .FRAME_LEN(FL), .WIN(WN), .STRIDE(3), .PAD(0)) if_a ();
    window_fetch_if #(.W(16), .FRAME_LEN(FL), .WIN(WN), .STRIDE(2), .PAD(2)) if_b ();

    window_fetch #(.W(16), .FRAME_LEN(FL), .WIN(WN), .STRIDE(3), .PAD(0)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_bus (if_a)
    );

    window_fetch #(.W(16), .FRAME_LEN(FL), .WIN(WN), .STRIDE(2), .PAD(2)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [127:0] pack(input logic last, input logic [7:0] idx,
                                          input logic [OW-1:0] data);
        return {39'b0, last, idx, data};
    endfunction

    // Window literal listed in element order 0..4.
    function automatic logic [OW-1:0] w5(input int e0, input int e1, input int e2,
                                         input int e3, input int e4);
        return {sample_t'(e4), sample_t'(e3), sample_t'(e2), sample_t'(e1), sample_t'(e0)};
    endfunction

    function automatic logic [FW-1:0] mk_frame(input int base);
        logic [FW-1:0] f;
        for (int i = 0; i < FL; i++) f[i*16 +: 16] = sample_t'(base + i + 1);
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // Window n, element k is frame[n*stride + k - pad], zero outside the frame.
    function automatic logic [OW-1:0] ref_win(input logic [FW-1:0] frame, input int n,
                                              input int stride, input int pad);
        logic [OW-1:0] r;
        int pos;
        r = '0;
        for (int k = 0; k < WN; k++) begin
            pos = n * stride + k - pad;
            if (pos >= 0 && pos < FL) r[k*16 +: 16] = frame[pos*16 +: 16];
        end
        return r;
    endfunction

    function automatic snap_t cap_a();
        snap_t s;
        s.in_valid  = if_a.in_valid;
        s.in_ready  = if_a.in_ready;
        s.clear     = if_a.clear;
        s.out_valid = if_a.out_valid;
        s.out_ready = if_a.out_ready;
        s.out_last  = if_a.out_last;
        s.empty     = if_a.empty;
        s.in_data   = if_a.in_data;
        s.out_data  = if_a.out_data;
        s.out_idx   = 8'(if_a.out_idx);
        return s;
    endfunction

    function automatic snap_t cap_b();
        snap_t s;
        s.in_valid  = if_b.in_valid;
        s.in_ready  = if_b.in_ready;
        s.clear     = if_b.clear;
        s.out_valid = if_b.out_valid;
        s.out_ready = if_b.out_ready;
        s.out_last  = if_b.out_last;
        s.empty     = if_b.empty;
        s.in_data   = if_b.in_data;
        s.out_data  = if_b.out_data;
        s.out_idx   = 8'(if_b.out_idx);
        return s;
    endfunction

    task automatic flush(input int d);
        if (d == 0) q_a.delete();
        else        q_b.delete();
        acc[d] = 0;
        pop[d] = 0;
    endtask

    // Scoreboard step for one DUT, given its state just before and just after an edge.
    task automatic score(input int d, input snap_t pre, input snap_t post);
        int    nw, st, pd, held, qs;
        vec_t  e;
        string tag;
        tag = (d == 0) ? "a" : "b";
        nw  = (d == 0) ? 6 : 10;
        st  = (d == 0) ? 3 : 2;
        pd  = (d == 0) ? 0 : 2;
        if (pre.clear) begin
            flush(d);
            return;
        end
        if (pre.out_valid && pre.out_ready) begin
            qs = (d == 0) ? q_a.size() : q_b.size();
            check({tag, "_sb_has_window"}, 128'(qs != 0), 128'(1));
            if (qs != 0) begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check({tag, "_sb_window"}, pack(pre.out_last, pre.out_idx, pre.out_data),
                      pack(e.last, e.idx, e.data));
            end
            pop[d]++;
        end
        if (pre.out_valid && !pre.out_ready) begin
            check({tag, "_stall_hold"}, pack(post.out_valid, post.out_idx, post.out_data) ^ 128'(post.out_last),
                  pack(1'b1, pre.out_idx, pre.out_data) ^ 128'(pre.out_last));
        end
        if (pre.in_valid && pre.in_ready) begin
            for (int n = 0; n < nw; n++) begin
                e.data = ref_win(pre.in_data, n, st, pd);
                e.idx  = 8'(n);
                e.last = (n == nw - 1);
                if (d == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
            acc[d]++;
        end
        // A frame gives up its buffer once its last window has been loaded.
        held = acc[d] - (pop[d] + int'(post.out_valid)) / nw;
        check({tag, "_in_ready"}, 128'(post.in_ready), 128'(held < 2));
        check({tag, "_empty"}, 128'(post.empty), 128'(held == 0 && !post.out_valid));
    endtask

    task automatic tick();
        snap_t pa, pb, qa, qb;
        pa = cap_a();
        pb = cap_b();
        @(posedge clk);
        #1;
        qa = cap_a();
        qb = cap_b();
        score(0, pa, qa);
        score(1, pb, qb);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_out_valid"}, 128'(if_a.out_valid), 128'(0));
        check({tag, "_out_data"},  128'(if_a.out_data),  128'(0));
        check({tag, "_out_idx"},   128'(if_a.out_idx),   128'(0));
        check({tag, "_out_last"},  128'(if_a.out_last),  128'(0));
        check({tag, "_in_ready"},  128'(if_a.in_ready),  128'(1));
        check({tag, "_empty"},     128'(if_a.empty),     128'(1));
    endtask

    initial begin
        int   streak, rise, first_last, cyc, p0, nb;
        logic accepted;
        logic pat [4];

        n_checks = 0;
        n_pass   = 0;
        flush(0);
        flush(1);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        tab[0] = '{8'd0, 1'b0, w5(1, 2, 3, 4, 5)};
        tab[1] = '{8'd1, 1'b0, w5(4, 5, 6, 7, 8)};
        tab[2] = '{8'd2, 1'b0, w5(7, 8, 9, 10, 11)};
        tab[3] = '{8'd3, 1'b0, w5(10, 11, 12, 13, 14)};
        tab[4] = '{8'd4, 1'b0, w5(13, 14, 15, 16, 17)};
        tab[5] = '{8'd5, 1'b1, w5(16, 17, 18, 19, 20)};
        pad_tab[0] = '{8'd0, 1'b0, w5(0, 0, 1, 2, 3)};
        pad_tab[1] = '{8'd9, 1'b1, w5(17, 18, 19, 20, 0)};

        if_a.clear = 0; if_a.in_valid = 0; if_a.in_data = '0; if_a.out_ready = 0;
        if_b.clear = 0; if_b.in_valid = 0; if_b.in_data = '0; if_b.out_ready = 0;

        // Reset values.
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_a("reset");
        check("reset_b_out_valid", 128'(if_b.out_valid), 128'(0));
        check("reset_b_empty", 128'(if_b.empty), 128'(1));
        rst_n = 1;

        // Single frame 1..20, consumer always ready, table of expected windows.
        if_a.in_data = mk_frame(0); if_a.in_valid = 1; if_a.out_ready = 1;
        tick();
        if_a.in_valid = 0;
        check("latency_not_yet_valid", 128'(if_a.out_valid), 128'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("tab_valid", 128'(if_a.out_valid), 128'(1));
            check("tab_window", pack(if_a.out_last, 8'(if_a.out_idx), if_a.out_data),
                  pack(tab[i].last, tab[i].idx, tab[i].data));
        end
        tick();
        check("after_last_valid", 128'(if_a.out_valid), 128'(0));
        check("after_last_empty", 128'(if_a.empty), 128'(1));

        // Back-to-back frames, third frame offered while both buffers are full.
        if_a.in_data = mk_frame(0); if_a.in_valid = 1;
        tick();
        if_a.in_data = mk_frame(100);
        tick();
        check("b2b_both_full_ready", 128'(if_a.in_ready), 128'(0));
        if_a.in_data = mk_frame(200);
        streak = if_a.out_valid ? 1 : 0;
        rise = -1; first_last = -1; cyc = 0;
        while (if_a.out_valid && cyc < 40) begin
            accepted = if_a.in_valid && if_a.in_ready;
            tick();
            cyc++;
            if (accepted) if_a.in_valid = 0;
            if (if_a.out_valid) streak++;
            if (first_last < 0 && if_a.out_last) first_last = cyc;
            if (rise < 0 && if_a.in_ready) rise = cyc;
        end
        check("b2b_streak", 128'(streak), 128'(18));
        check("b2b_first_last_cycle", 128'(first_last), 128'(5));
        check("b2b_ready_rises_with_last", 128'(rise), 128'(first_last));

        // Consumer stalls with out_ready pattern 1,0,0,1.
        if_a.in_data = mk_frame(400); if_a.in_valid = 1; if_a.out_ready = 1;
        tick();
        if_a.in_valid = 0;
        p0 = pop[0];
        for (int c = 0; c < 40 && (c == 0 || if_a.out_valid); c++) begin
            if_a.out_ready = pat[c % 4];
            tick();
        end
        check("stall_window_count", 128'(pop[0] - p0), 128'(6));
        check("stall_sb_drained", 128'(q_a.size()), 128'(0));
        if_a.out_ready = 1;

        // Padded geometry on the second instance.
        if_b.in_data = mk_frame(0); if_b.in_valid = 1; if_b.out_ready = 1;
        tick();
        if_b.in_valid = 0;
        nb = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (if_b.out_valid) begin
                nb++;
                for (int j = 0; j < 2; j++) begin
                    if (8'(if_b.out_idx) == pad_tab[j].idx)
                        check("pad_table_window", pack(if_b.out_last, 8'(if_b.out_idx), if_b.out_data),
                              pack(pad_tab[j].last, pad_tab[j].idx, pad_tab[j].data));
                end
            end
        end
        check("pad_window_count", 128'(nb), 128'(10));

        // Clear after window 2; a frame offered in the clear cycle is not taken.
        if_a.in_data = mk_frame(500); if_a.in_valid = 1; if_a.out_ready = 1;
        tick();
        if_a.in_valid = 0;
        cyc = 0;
        while (!(if_a.out_valid && if_a.out_idx == 3'd2) && cyc < 10) begin
            tick();
            cyc++;
        end
        check("clr_reached_w2", 128'(if_a.out_idx), 128'(2));
        if_a.clear = 1; if_a.in_valid = 1; if_a.in_data = mk_frame(600);
        tick();
        if_a.clear = 0; if_a.in_valid = 0;
        check_idle_a("clr");
        tick();
        tick();
        check("clr_no_transfer", 128'(if_a.out_valid), 128'(0));
        if_a.in_data = mk_frame(700); if_a.in_valid = 1;
        tick();
        if_a.in_valid = 0;
        tick();
        check("clr_restart_w0", pack(if_a.out_last, 8'(if_a.out_idx), if_a.out_data),
              pack(1'b0, 8'd0, w5(701, 702, 703, 704, 705)));
        repeat (8) tick();

        // Asynchronous reset in the middle of a frame with a second frame buffered.
        if_a.in_data = mk_frame(800); if_a.in_valid = 1;
        tick();
        if_a.in_data = mk_frame(900);
        tick();
        if_a.in_valid = 0;
        tick();
        #2 rst_n = 0;
        #1;
        check_idle_a("rst_mid");
        flush(0);
        flush(1);
        @(negedge clk);
        rst_n = 1;
        if_a.in_data = mk_frame(1000); if_a.in_valid = 1;
        tick();
        if_a.in_valid = 0;
        check("rst_restart_latency", 128'(if_a.out_valid), 128'(0));
        tick();
        check("rst_restart_w0", pack(if_a.out_last, 8'(if_a.out_idx), if_a.out_data),
              pack(1'b0, 8'd0, w5(1001, 1002, 1003, 1004, 1005)));
        repeat (8) tick();

        // Random traffic on both instances against the scoreboard.
        for (int c = 0; c < 800; c++) begin
            if_a.in_valid  = ($urandom_range(0, 3) == 0);
            if_a.in_data   = rand_frame();
            if_a.out_ready = ($urandom_range(0, 3) != 0);
            if_a.clear     = ($urandom_range(0, 99) == 0);
            if_b.in_valid  = ($urandom_range(0, 5) == 0);
            if_b.in_data   = rand_frame();
            if_b.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        if_a.clear = 0; if_a.in_valid = 0; if_a.out_ready = 1;
        if_b.in_valid = 0; if_b.out_ready = 1;
        repeat (30) tick();
        check("rand_a_drained", 128'(q_a.size()), 128'(0));
        check("rand_b_drained", 128'(q_b.size()), 128'(0));
        check("rand_a_empty", 128'(if_a.empty), 128'(1));
        check("rand_b_empty", 128'(if_b.empty), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
